// File: rtl/event_interval_monitor_pkg.sv
// event_interval_monitor_pkg: shared delay-type constants and monitor state encodings
package event_interval_monitor_pkg;

  typedef enum logic [1:0] {
    no_delay,
    fixed_delay,
    diff_delay,
    random_delay
  } delay_type_e;

  typedef enum logic {
    IDLE,
    ARMED
  } state_e;

endpackage

// File: rtl/event_interval_monitor_sync_edge_detect.sv
// sync_edge_detect: multi-flop synchroniser followed by a rising-edge detector
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic async_in,
  output logic rise_pulse
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  // shift the raw input through the chain and remember the last synchronised level
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // synchroniser and history flops
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/event_interval_monitor.sv
// event_interval_monitor: measures event1-to-event2 intervals in clock cycles with limit checks and statistics
module event_interval_monitor
  import event_interval_monitor_pkg::*;
#(
  parameter int COUNT_WIDTH      = 8,
  parameter int MAX_DELAY_CYCLES = 20,
  parameter int MIN_DELAY_CYCLES = 0,
  parameter int SYNC_STAGES      = 2
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   clear_stats,
  input  logic                   event1,
  input  logic                   event2,
  output logic [COUNT_WIDTH-1:0] interval,
  output logic                   interval_valid,
  output logic [COUNT_WIDTH-1:0] min_interval,
  output logic [COUNT_WIDTH-1:0] max_interval,
  output logic [COUNT_WIDTH-1:0] sample_count,
  output logic                   min_violation,
  output logic                   max_violation,
  output logic [COUNT_WIDTH-1:0] violation_count,
  output logic                   busy
);

  localparam logic [COUNT_WIDTH-1:0] ONES    = '1;
  localparam logic [COUNT_WIDTH-1:0] MAX_CNT = COUNT_WIDTH'(MAX_DELAY_CYCLES);
  localparam logic [COUNT_WIDTH+1:0] MIN_EXT = (COUNT_WIDTH+2)'(MIN_DELAY_CYCLES);

  logic                   e1_rise, e2_rise;
  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0] interval_q, interval_d;
  logic                   valid_q, valid_d;
  logic [COUNT_WIDTH-1:0] min_q, min_d;
  logic [COUNT_WIDTH-1:0] max_q, max_d;
  logic [COUNT_WIDTH-1:0] samples_q, samples_d;
  logic                   minv_q, minv_d;
  logic                   maxv_q, maxv_d;
  logic [COUNT_WIDTH-1:0] viol_q, viol_d;
  logic                   pub, timeout, short_pub;
  logic [COUNT_WIDTH-1:0] pub_val;
  logic [COUNT_WIDTH-1:0] min_b, max_b, samples_b, viol_b;
  logic [COUNT_WIDTH+1:0] min_diff;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_e1 (
    .clock     (clock),
    .reset_n   (reset_n),
    .async_in  (event1),
    .rise_pulse(e1_rise)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_e2 (
    .clock     (clock),
    .reset_n   (reset_n),
    .async_in  (event2),
    .rise_pulse(e2_rise)
  );

  // measurement sequencing: arm on e1, publish on e2, give up after the max interval
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pub     = 1'b0;
    timeout = 1'b0;
    pub_val = cnt_q + COUNT_WIDTH'(1);
    if (!enable) begin
      state_d = IDLE;
    end else if (state_q == IDLE) begin
      if (e1_rise && e2_rise) begin
        pub     = 1'b1;
        pub_val = '0;
      end else if (e1_rise) begin
        state_d = ARMED;
        cnt_d   = '0;
      end
    end else begin
      if (e2_rise) begin
        pub     = 1'b1;
        state_d = e1_rise ? ARMED : IDLE;
        cnt_d   = '0;
      end else if (e1_rise) begin
        cnt_d   = '0;
      end else if (cnt_q == MAX_CNT) begin
        timeout = 1'b1;
        state_d = IDLE;
      end else begin
        cnt_d   = cnt_q + COUNT_WIDTH'(1);
      end
    end
  end

  // statistics update; a coincident clear starts from the reset values so the new sample still counts
  always_comb begin
    min_diff   = MIN_EXT - {2'b00, pub_val};
    short_pub  = pub & ~min_diff[COUNT_WIDTH+1] & (|min_diff);
    min_b      = clear_stats ? ONES : min_q;
    max_b      = clear_stats ? '0 : max_q;
    samples_b  = clear_stats ? '0 : samples_q;
    viol_b     = clear_stats ? '0 : viol_q;
    interval_d = pub ? pub_val : interval_q;
    valid_d    = pub;
    min_d      = (pub && pub_val < min_b) ? pub_val : min_b;
    max_d      = (pub && pub_val > max_b) ? pub_val : max_b;
    samples_d  = (pub && samples_b != ONES) ? samples_b + COUNT_WIDTH'(1) : samples_b;
    minv_d     = short_pub;
    maxv_d     = timeout;
    viol_d     = ((short_pub || timeout) && viol_b != ONES) ? viol_b + COUNT_WIDTH'(1) : viol_b;
  end

  // state, counter and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      interval_q <= '0;
      valid_q    <= 1'b0;
      min_q      <= ONES;
      max_q      <= '0;
      samples_q  <= '0;
      minv_q     <= 1'b0;
      maxv_q     <= 1'b0;
      viol_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      interval_q <= interval_d;
      valid_q    <= valid_d;
      min_q      <= min_d;
      max_q      <= max_d;
      samples_q  <= samples_d;
      minv_q     <= minv_d;
      maxv_q     <= maxv_d;
      viol_q     <= viol_d;
    end
  end

  assign interval        = interval_q;
  assign interval_valid  = valid_q;
  assign min_interval    = min_q;
  assign max_interval    = max_q;
  assign sample_count    = samples_q;
  assign min_violation   = minv_q;
  assign max_violation   = maxv_q;
  assign violation_count = viol_q;
  assign busy            = (state_q == ARMED);

endmodule
